stopwatch_core: RTL and testbench
=================================

# stopwatch_core

Single-clock, parametrised MM:SS stopwatch/timer core, the successor to the board-level stopwatch datapath. It replaces the divided-clock counter with an internal clock-enable prescaler. It adds a configurable minute-field width, a lap/split capture register, and a DONE state for count-down expiry and count-up saturation. The core sits between the button debouncers, which supply single-cycle pulses, and the 7-segment multiplexer, which consumes packed BCD digits and a blink phase.

## Interface
- `TICK_DIV`, 100_000_000: clk cycles per count tick (1 Hz at 100 MHz); must be ≥ 2.
- `BLINK_HALF`, 25_000_000: clk cycles per blink half-period (2 Hz blink at 100 MHz).
- `MIN_DIGITS`, 2: BCD digits in the minute field; minute range 0..10^MIN_DIGITS−1.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start_stop` in 1: debounced one-cycle pulse; run/stop toggle.
- `lap` in 1: debounced one-cycle pulse; capture split.
- `inc` in 1: debounced one-cycle pulse; adjust +1.
- `dec` in 1: debounced one-cycle pulse; adjust −1.
- `adj` in 1: level; request adjust mode.
- `sel` in 1: level; adjust field select (0 = seconds, 1 = minutes).
- `cnt_dn` in 1: level; 1 = count down, 0 = count up.
- `disp` out 4*(MIN_DIGITS+2): packed BCD, most-significant minute digit at top; shows the lap register when `lap_active`=1, otherwise the live count.
- `running` out 1: high in RUN.
- `lap_active` out 1: display is frozen on the captured split.
- `done` out 1: one-cycle pulse on entry to DONE.
- `expired` out 1: high while in DONE.
- `blink` out 1: free-running 50% square wave, period 2*BLINK_HALF cycles, for the adjust-field flash.

## Operation
- All outputs are registered. On reset: state STOP, count 00:00, lap register 00:00, prescaler 0, blink counter 0, and all 1-bit outputs 0.
- Count format:
  - seconds are 2 BCD digits, 00..59;
  - minutes are MIN_DIGITS BCD digits, 0..MMAX, where MMAX = 10^MIN_DIGITS−1;
  - a carry or borrow between the fields uses BCD arithmetic only (no binary-to-BCD conversion).
- Prescaler: counts 0..TICK_DIV−1 only in RUN and is cleared on every entry to RUN. `tick` is asserted internally when the prescaler equals TICK_DIV−1.
- Blink counter: runs in all states, cleared only by `rst`.
- States:
  - STOP:
    - `adj`=1 → ADJ (this takes priority over `start_stop`);
    - `start_stop` → RUN, except when `cnt_dn`=1 and count=00:00, where the pulse is ignored.
  - RUN, on `tick`:
    - up: count+1, 00:59→01:00. Reaching MMAX:59 → DONE, holding MMAX:59.
    - down: count−1, 01:00→00:59. Reaching 00:00 → DONE.
    - `start_stop` → STOP. `adj` is ignored in RUN.
  - ADJ:
    - `inc` adds 1 to the selected field only; `dec` subtracts 1 from the selected field only;
    - seconds wrap 59↔00, minutes wrap MMAX↔0, and there is no carry into the other field;
    - `inc` and `dec` in the same cycle → no change;
    - `adj`=0 → STOP;
    - `start_stop` and `lap` are ignored.
  - DONE:
    - `start_stop` → STOP with the count held;
    - `adj`=1 → ADJ;
    - ticks are ignored.
- Direction: `cnt_dn` is sampled on each tick, so a change mid-run takes effect on the next tick.
- Lap:
  - in RUN, `lap` copies the current count register (the pre-tick value, even if a tick occurs in the same cycle) into the lap register and sets `lap_active`; a further `lap` refreshes the split;
  - in STOP or DONE, `lap` clears `lap_active`;
  - entry to ADJ clears `lap_active`.
- Simultaneous events in RUN:
  - `tick` + `start_stop`: the tick is applied and the state becomes STOP;
  - a `tick` that reaches the terminal value + `start_stop`: DONE wins.

## Timing
- `start_stop` pulse in cycle N (STOP) → `running`=1 and prescaler=0 from N+1. The first tick is asserted in cycle N+TICK_DIV, and the count updates at N+TICK_DIV+1.
- Steady state: one count change every TICK_DIV cycles.
- Terminal tick in cycle T → in cycle T+1: `disp` shows the terminal value, `done`=1 and `expired`=1, `running`=0. `done` deasserts at T+2.
- `inc`/`dec`/`lap`/`adj` in cycle N → the `disp` or state change is visible at N+1.
- `blink` toggles every BLINK_HALF cycles after reset is released.

## Test plan
Run with TICK_DIV=4, BLINK_HALF=2, MIN_DIGITS=2.
- Reset, then `start_stop` with `cnt_dn`=0, and wait 60 ticks → `disp`=0x0100 (01:00), `running`=1. The first change is exactly 4 cycles after the pulse.
- ADJ, `sel`=0, preset 00:03, release `adj`, set `cnt_dn`=1, `start_stop` → count 00:02, 00:01, 00:00, then `done` is a single-cycle pulse, `expired`=1, `running`=0. A further `start_stop` → STOP; a `start_stop` while at 00:00 is then ignored.
- ADJ `sel`=1: `dec` from 00 → 99; `sel`=0: `inc` from 59 → 00 with minutes unchanged; `inc`+`dec` in the same cycle → no change.
- RUN up, `lap` at 00:05 → `disp` frozen at 0x0005 while the internal count advances. `start_stop` then `lap` → `disp` shows the live count.
- Preset 99:58 and count up → 99:59, then DONE, holding 0x9959 with no wrap.
- Assert `rst` mid-RUN coincident with a tick → next cycle: count 00:00, STOP, all flags 0.

Source files
------------

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch/timer core: BCD count up/down with tick prescaler, field adjust,
// lap capture, DONE on count-down expiry or count-up saturation, and a blink phase.
`timescale 1ns/1ps
module stopwatch_core #(
    parameter int TICK_DIV   = 100_000_000,
    parameter int BLINK_HALF = 25_000_000,
    parameter int MIN_DIGITS = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_stop,
    input  logic                        lap,
    input  logic                        inc,
    input  logic                        dec,
    input  logic                        adj,
    input  logic                        sel,
    input  logic                        cnt_dn,
    output logic [4*(MIN_DIGITS+2)-1:0] disp,
    output logic                        running,
    output logic                        lap_active,
    output logic                        done,
    output logic                        expired,
    output logic                        blink
);

    localparam int MW = 4 * MIN_DIGITS;
    localparam int CW = MW + 8;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [MW-1:0] MMAX       = {MIN_DIGITS{4'h9}};
    localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        ST_STOP,
        ST_RUN,
        ST_ADJ,
        ST_DONE
    } state_t;

    function automatic logic [7:0] sec_inc(input logic [7:0] s);
        if (s == 8'h59) return 8'h00;
        if (s[3:0] == 4'h9) return {s[7:4] + 4'h1, 4'h0};
        return {s[7:4], s[3:0] + 4'h1};
    endfunction

    function automatic logic [7:0] sec_dec(input logic [7:0] s);
        if (s == 8'h00) return 8'h59;
        if (s[3:0] == 4'h0) return {s[7:4] - 4'h1, 4'h9};
        return {s[7:4], s[3:0] - 4'h1};
    endfunction

    // Ripple a BCD carry through the minute digits; all-nines wraps to zero.
    function automatic logic [MW-1:0] min_inc(input logic [MW-1:0] m);
        logic [MW-1:0] r;
        logic          carry;
        r     = m;
        carry = 1'b1;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (carry) begin
                if (m[4*i +: 4] == 4'h9) begin
                    r[4*i +: 4] = 4'h0;
                end else begin
                    r[4*i +: 4] = m[4*i +: 4] + 4'h1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [MW-1:0] min_dec(input logic [MW-1:0] m);
        logic [MW-1:0] r;
        logic          borrow;
        r      = m;
        borrow = 1'b1;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (borrow) begin
                if (m[4*i +: 4] == 4'h0) begin
                    r[4*i +: 4] = 4'h9;
                end else begin
                    r[4*i +: 4] = m[4*i +: 4] - 4'h1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    state_t        state_q, state_d;
    logic [7:0]    sec_q, sec_d;
    logic [MW-1:0] min_q, min_d;
    logic [CW-1:0] lap_q, lap_d;
    logic          lap_active_q, lap_active_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    logic [CW-1:0] disp_q, disp_d;
    logic          running_q, running_d;
    logic          done_q, done_d;
    logic          expired_q, expired_d;

    logic          tick;
    logic [CW-1:0] limit;
    logic [7:0]    sec_t;
    logic [MW-1:0] min_t;
    logic          terminal;

    assign tick = (state_q == ST_RUN) && (pre_q == PRE_LAST);

    // Count value a tick would produce; at the limit already, the count saturates.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        sec_t = sec_q;
        min_t = min_q;
        limit = cnt_dn ? '0 : {MMAX, 8'h59};
        if ({min_q, sec_q} != limit) begin
            if (cnt_dn) begin
                if (sec_q == 8'h00) begin
                    sec_t = 8'h59;
                    min_t = min_dec(min_q);
                end else begin
                    sec_t = sec_dec(sec_q);
                end
            end else begin
                if (sec_q == 8'h59) begin
                    sec_t = 8'h00;
                    min_t = min_inc(min_q);
                end else begin
                    sec_t = sec_inc(sec_q);
                end
            end
        end
        terminal = ({min_t, sec_t} == limit);
    end

    always_comb begin
        state_d      = state_q;
        sec_d        = sec_q;
        min_d        = min_q;
        lap_d        = lap_q;
        lap_active_d = lap_active_q;
        pre_d        = '0;
        unique case (state_q)
            ST_STOP: begin
                if (lap) lap_active_d = 1'b0;
                if (adj) begin
                    state_d      = ST_ADJ;
                    lap_active_d = 1'b0;
                end else if (start_stop && !(cnt_dn && ({min_q, sec_q} == '0))) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                pre_d = tick ? '0 : pre_q + 1'b1;
                if (lap) begin
                    lap_d        = {min_q, sec_q};
                    lap_active_d = 1'b1;
                end
                if (tick) begin
                    sec_d = sec_t;
                    min_d = min_t;
                end
                if (tick && terminal) state_d = ST_DONE;
                else if (start_stop)  state_d = ST_STOP;
            end
            ST_ADJ: begin
                if (inc != dec) begin
                    if (sel) min_d = inc ? min_inc(min_q) : min_dec(min_q);
                    else     sec_d = inc ? sec_inc(sec_q) : sec_dec(sec_q);
                end
                if (!adj) state_d = ST_STOP;
            end
            ST_DONE: begin
                if (lap) lap_active_d = 1'b0;
                if (adj) begin
                    state_d      = ST_ADJ;
                    lap_active_d = 1'b0;
                end else if (start_stop) begin
                    state_d = ST_STOP;
                end
            end
            default: state_d = ST_STOP;
        endcase

        blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
        blink_d     = (blink_cnt_q == BLINK_LAST) ? ~blink_q : blink_q;

        disp_d    = lap_active_d ? lap_d : {min_d, sec_d};
        running_d = (state_d == ST_RUN);
        expired_d = (state_d == ST_DONE);
        done_d    = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_STOP;
            sec_q        <= '0;
            min_q        <= '0;
            lap_q        <= '0;
            lap_active_q <= 1'b0;
            pre_q        <= '0;
            blink_cnt_q  <= '0;
            blink_q      <= 1'b0;
            disp_q       <= '0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            expired_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values together.
            state_q      <= state_d;
            sec_q        <= sec_d;
            min_q        <= min_d;
            lap_q        <= lap_d;
            lap_active_q <= lap_active_d;
            pre_q        <= pre_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_q      <= blink_d;
            disp_q       <= disp_d;
            running_q    <= running_d;
            done_q       <= done_d;
            expired_q    <= expired_d;
        end
    end

    assign disp       = disp_q;
    assign running    = running_q;
    assign lap_active = lap_active_q;
    assign done       = done_q;
    assign expired    = expired_q;
    assign blink      = blink_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core with TICK_DIV=4, BLINK_HALF=2, MIN_DIGITS=2.
`timescale 1ns/1ps
module tb_stopwatch_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_stop = 1'b0;
    logic        lap = 1'b0;
    logic        inc = 1'b0;
    logic        dec = 1'b0;
    logic        adj = 1'b0;
    logic        sel = 1'b0;
    logic        cnt_dn = 1'b0;
    logic [15:0] disp;
    logic        running;
    logic        lap_active;
    logic        done;
    logic        expired;
    logic        blink;

    int n_checks = 0;
    int n_fails  = 0;

    stopwatch_core #(
        .TICK_DIV  (4),
        .BLINK_HALF(2),
        .MIN_DIGITS(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_stop(start_stop),
        .lap       (lap),
        .inc       (inc),
        .dec       (dec),
        .adj       (adj),
        .sel       (sel),
        .cnt_dn    (cnt_dn),
        .disp      (disp),
        .running   (running),
        .lap_active(lap_active),
        .done      (done),
        .expired   (expired),
        .blink     (blink)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Advance n clock edges, then settle 1 ns past the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle pulse on {start_stop, lap, inc, dec}.
    task automatic pulse(input logic [3:0] m);
        {start_stop, lap, inc, dec} = m;
        step(1);
        {start_stop, lap, inc, dec} = 4'b0000;
    endtask

    localparam logic [3:0] P_SS  = 4'b1000;
    localparam logic [3:0] P_LAP = 4'b0100;
    localparam logic [3:0] P_INC = 4'b0010;
    localparam logic [3:0] P_DEC = 4'b0001;

    initial begin
        #100_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_blink;

        // Reset state and blink phase
        step(1);
        check("rst_disp", 32'(disp), 32'h0000);
        check("rst_flags", 32'({running, lap_active, done, expired, blink}), 32'h0);
        rst = 1'b0;
        exp_blink = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("blink", 32'(blink), 32'(exp_blink[i]));
        end

        // Count up: first change 4 cycles after running rises, then 01:00 after 60 ticks
        pulse(P_SS);
        check("up_running", 32'(running), 32'h1);
        step(3);
        check("up_pre_tick", 32'(disp), 32'h0000);
        step(1);
        check("up_first_tick", 32'(disp), 32'h0001);
        step(232);
        check("up_0059", 32'(disp), 32'h0059);
        step(4);
        check("up_0100", 32'(disp), 32'h0100);
        check("up_0100_running", 32'(running), 32'h1);
        pulse(P_SS);
        check("up_stopped", 32'(running), 32'h0);

        // Preset 00:03 and count down to expiry
        adj = 1'b1;
        sel = 1'b1;
        step(1);
        pulse(P_DEC);
        check("adj_min_dec", 32'(disp), 32'h0000);
        sel = 1'b0;
        repeat (3) pulse(P_INC);
        check("adj_preset_03", 32'(disp), 32'h0003);
        adj = 1'b0;
        cnt_dn = 1'b1;
        step(1);
        pulse(P_SS);
        step(4);
        check("dn_0002", 32'(disp), 32'h0002);
        step(4);
        check("dn_0001", 32'(disp), 32'h0001);
        step(4);
        check("dn_0000", 32'(disp), 32'h0000);
        check("dn_done_flags", 32'({done, expired, running}), 32'b110);
        step(1);
        check("dn_done_pulse", 32'({done, expired, running}), 32'b010);
        pulse(P_SS);
        check("dn_to_stop", 32'({disp, expired, running}), 32'h0);
        pulse(P_SS);
        step(2);
        check("dn_zero_ignored", 32'({disp, running}), 32'h0);

        // Adjust wraps and simultaneous inc/dec
        adj = 1'b1;
        sel = 1'b1;
        step(1);
        pulse(P_DEC);
        check("adj_min_wrap_dn", 32'(disp), 32'h9900);
        sel = 1'b0;
        pulse(P_DEC);
        check("adj_sec_wrap_dn", 32'(disp), 32'h9959);
        pulse(P_INC);
        check("adj_sec_wrap_up", 32'(disp), 32'h9900);
        pulse(P_INC | P_DEC);
        check("adj_inc_dec", 32'(disp), 32'h9900);
        sel = 1'b1;
        pulse(P_INC);
        check("adj_min_wrap_up", 32'(disp), 32'h0000);

        // Lap capture freezes the display while the count advances
        adj = 1'b0;
        cnt_dn = 1'b0;
        step(1);
        pulse(P_SS);
        step(20);
        check("lap_pre", 32'(disp), 32'h0005);
        pulse(P_LAP);
        check("lap_set", 32'({disp, 3'b000, lap_active}), 32'h00051);
        step(8);
        check("lap_frozen", 32'({disp, 3'b000, lap_active}), 32'h00051);
        pulse(P_SS);
        check("lap_stop", 32'({disp, 3'b000, running}), 32'h00050);
        pulse(P_LAP);
        check("lap_clear", 32'({disp, 3'b000, lap_active}), 32'h00070);

        // Count-up saturation at 99:59, lap coincident with the terminal tick
        adj = 1'b1;
        sel = 1'b1;
        step(1);
        pulse(P_DEC);
        sel = 1'b0;
        repeat (9) pulse(P_DEC);
        check("sat_preset", 32'(disp), 32'h9958);
        adj = 1'b0;
        step(1);
        pulse(P_SS);
        step(3);
        pulse(P_LAP);
        check("sat_lap_pretick", 32'({disp, 3'b000, lap_active}), 32'h99581);
        check("sat_done_flags", 32'({done, expired, running}), 32'b110);
        pulse(P_LAP);
        check("sat_hold", 32'({disp, 3'b000, lap_active}), 32'h99590);
        check("sat_done_once", 32'({done, expired}), 32'b01);
        step(8);
        check("sat_no_wrap", 32'({disp, 3'b000, expired}), 32'h99591);

        // Reset mid-run coincident with a tick
        pulse(P_SS);
        cnt_dn = 1'b1;
        pulse(P_SS);
        pulse(P_LAP);
        check("rst_run_pre", 32'({lap_active, running}), 32'b11);
        step(2);
        rst = 1'b1;
        step(1);
        check("rst_run_disp", 32'(disp), 32'h0000);
        check("rst_run_flags", 32'({running, lap_active, done, expired}), 32'h0);
        rst = 1'b0;
        cnt_dn = 1'b0;
        step(6);
        check("rst_run_stopped", 32'({disp, running}), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
